// File: rtl/keypad_scanner.sv
// Row-scanning matrix keypad controller: drives one active-low row at a time,
// debounces press and release of a single key and reports its scan code.
module keypad_scanner #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CODE_W          = $clog2(ROWS * COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [COLS-1:0]   kc,
  output logic [ROWS-1:0]   kr,
  output logic              press,
  output logic [CODE_W-1:0] scan_code,
  output logic              key_valid
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int BW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_CYCLES - 1);
  localparam logic [BW-1:0]   DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0]   ROW_LAST   = RW'(ROWS - 1);
  localparam logic [ROWS-1:0] KR_RESET   = {{(ROWS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE_P,
    HELD,
    DEBOUNCE_R
  } state_e;

  state_e            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [ROWS-1:0]   kr_q, kr_d;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic [BW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     cand_col_q, cand_col_d;
  logic [COLS-1:0]   cand_pat_q, cand_pat_d;
  logic              entered_q, entered_d;
  logic              press_q, press_d;
  logic [CODE_W-1:0] scan_code_q, scan_code_d;
  logic              key_valid_q, key_valid_d;

  logic [COLS-1:0]   low_bits;
  logic              col_single;
  logic [CW-1:0]     low_col;
  logic [RW-1:0]     row_nxt;
  logic [ROWS-1:0]   kr_nxt;
  logic [CODE_W-1:0] code;

  // Exactly one column low is a one-hot test on the inverted sense lines.
  always_comb begin
    low_bits   = ~kc;
    col_single = (low_bits != '0) && ((low_bits & (low_bits - 1'b1)) == '0);
    low_col    = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      if (low_bits[c]) low_col = CW'(c);
    end
  end

  always_comb begin
    row_nxt = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    kr_nxt  = '1;
    for (int unsigned r = 0; r < ROWS; r++) begin
      kr_nxt[r] = (row_nxt != RW'(r));
    end
    code = CODE_W'(int'(row_q) * COLS + int'(cand_col_q));
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    kr_d        = kr_q;
    dwell_d     = dwell_q;
    cnt_d       = cnt_q;
    cand_col_d  = cand_col_q;
    cand_pat_d  = cand_pat_q;
    entered_d   = 1'b0;
    press_d     = press_q;
    scan_code_d = scan_code_q;
    key_valid_d = 1'b0;

    // Accepted-key outputs are registered off the first cycle spent in HELD.
    if (entered_q) begin
      key_valid_d = 1'b1;
      press_d     = 1'b1;
      scan_code_d = code;
    end

    unique case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (col_single) begin
            state_d    = DEBOUNCE_P;
            cnt_d      = '0;
            cand_col_d = low_col;
            cand_pat_d = kc;
          end else begin
            row_d = row_nxt;
            kr_d  = kr_nxt;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      DEBOUNCE_P: begin
        if (kc == cand_pat_q) begin
          if (cnt_q == DEB_LAST) begin
            state_d   = HELD;
            entered_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d = SCAN;
          dwell_d = '0;
        end
      end
      HELD: begin
        if (kc[cand_col_q]) begin
          state_d = DEBOUNCE_R;
          cnt_d   = '0;
        end
      end
      DEBOUNCE_R: begin
        if (!kc[cand_col_q]) begin
          state_d = HELD;
        end else if (cnt_q == DEB_LAST) begin
          state_d = SCAN;
          press_d = 1'b0;
          row_d   = row_nxt;
          kr_d    = kr_nxt;
          dwell_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SCAN;
      row_q       <= '0;
      kr_q        <= KR_RESET;
      dwell_q     <= '0;
      cnt_q       <= '0;
      cand_col_q  <= '0;
      cand_pat_q  <= '1;
      entered_q   <= 1'b0;
      press_q     <= 1'b0;
      scan_code_q <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      kr_q        <= kr_d;
      dwell_q     <= dwell_d;
      cnt_q       <= cnt_d;
      cand_col_q  <= cand_col_d;
      cand_pat_q  <= cand_pat_d;
      entered_q   <= entered_d;
      press_q     <= press_d;
      scan_code_q <= scan_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign kr        = kr_q;
  assign press     = press_q;
  assign scan_code = scan_code_q;
  assign key_valid = key_valid_q;

endmodule
